muldiv_unit: RTL and testbench

- Execute-stage consumer of the decode control word for the multiply/divide group: acts on alu_funct codes 1011 (MULT), 1100 (MULTU), 1101 (DIV) and 1110 (DIVU), plus hi_write/lo_write for MTHI/MTLO.
- Owns the architectural HI/LO registers and feeds them back to MFHI/MFLO.
- Multi-cycle iterative shift-add multiplier and restoring divider.
- The pipeline stalls on busy.

---
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider owning HI/LO
// MULDIV_FAST_MUL_EN: multiplies use a single-cycle product and skip RUN; divide unchanged
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] F_MULT  = 4'b1011;
  localparam logic [3:0] F_MULTU = 4'b1100;
  localparam logic [3:0] F_DIV   = 4'b1101;
  localparam logic [3:0] F_DIVU  = 4'b1110;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   raw_a;
  logic               op_div, neg_res, neg_rem, div_zero;

  logic               legal, is_div_in, signed_in, fast_mul;
  logic [WIDTH-1:0]   abs_a, abs_b;

  assign legal     = funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  assign is_div_in = (funct == F_DIV) || (funct == F_DIVU);
  assign signed_in = (funct == F_MULT) || (funct == F_DIV);
  assign abs_a     = (signed_in && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (signed_in && b[WIDTH-1]) ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{WIDTH{signed_in & a[WIDTH-1]}}, a};
  assign ext_b     = {{WIDTH{signed_in & b[WIDTH-1]}}, b};
  assign fast_prod = ext_a * ext_b;
  assign fast_mul  = !is_div_in;
`else
  assign fast_mul  = 1'b0;
`endif

  // Multiply step: multiplier sits in the low half of acc and shifts out as the product shifts in.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: dividend shifts out of acc[WIDTH-1] while quotient bits shift in at the bottom.
  logic [WIDTH:0]   div_shift, div_diff, rem_next;
  logic             div_ge;
  logic [WIDTH-1:0] q_next;
  assign div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign div_ge    = {rem, acc[WIDTH-1]} >= {2'b00, opb};
  assign div_diff  = div_shift - {1'b0, opb};
  assign rem_next  = div_ge ? div_diff : div_shift;
  assign q_next    = {acc[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rmd_fix;
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rmd_fix  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && legal) state_next = fast_mul ? FIX : RUN;
      RUN:     if (cnt == CW'(WIDTH-1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush && state != IDLE) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      rem      <= '0;
      opb      <= '0;
      raw_a    <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state == FIX) && !flush;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && legal) begin
            op_div   <= is_div_in;
            neg_res  <= signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= signed_in & a[WIDTH-1];
            div_zero <= is_div_in && (b == '0);
            raw_a    <= a;
            opb      <= is_div_in ? abs_b : abs_a;
            acc      <= is_div_in ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            rem      <= '0;
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div_in) begin
              acc     <= fast_prod;
              neg_res <= 1'b0;
            end
`endif
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (op_div) begin
            acc[WIDTH-1:0] <= q_next;
            rem            <= rem_next;
          end else begin
            acc <= mul_next;
          end
        end
        FIX: begin
          if (!flush) begin
            if (!op_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (div_zero) begin
              hi <= raw_a;
              lo <= '1;
            end else begin
              hi <= rmd_fix;
              lo <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;
  localparam logic [3:0] F_MULT  = 4'b1011;
  localparam logic [3:0] F_MULTU = 4'b1100;
  localparam logic [3:0] F_DIV   = 4'b1101;
  localparam logic [3:0] F_DIVU  = 4'b1110;

  logic         clk = 1'b0;
  logic         reset, start, hi_we, lo_we, flush;
  logic [3:0]   funct;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad = 0;
  logic [2*W-1:0] sb_q[$];
  logic [W-1:0]   cur_hi, cur_lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  function automatic logic [2*W-1:0] model(input logic [3:0] f, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy, sq, sr;
    logic [2*W-1:0] r;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    r = '0;
    if (f == F_MULT) r = sx * sy;
    else if (f == F_MULTU) r = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    else if (y == '0) r = {x, {W{1'b1}}};
    else if (f == F_DIV) begin
      sq = sx / sy;
      sr = sx % sy;
      r = {sr[W-1:0], sq[W-1:0]};
    end else r = {x % y, x / y};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit expect_result);
    funct = f;
    a = x;
    b = y;
    start = 1'b1;
    if (expect_result) sb_q.push_back(model(f, x, y));
    tick();
    start = 1'b0;
  endtask

  task automatic await_done(input int from_cyc, output int lat, output bit busy_ok,
                            output logic busy_at_done);
    bit found;
    found = 0;
    lat = -1;
    busy_ok = 1;
    busy_at_done = 1'bx;
    for (int c = from_cyc; c < from_cyc + 80 && !found; c++) begin
      if (done === 1'b1) begin
        found = 1;
        lat = c;
        busy_at_done = busy;
      end else begin
        if (busy !== 1'b1) busy_ok = 0;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; funct = 4'b0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; flush = 1'b0;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
    total++; if (hi !== '0) begin bad++; $display("FAIL reset hi: got %h want 0", hi); end
    total++; if (lo !== '0) begin bad++; $display("FAIL reset lo: got %h want 0", lo); end
    reset = 1'b0;
    cur_hi = '0;
    cur_lo = '0;
    tick();
  endtask

  task automatic test_multu_max();
    int lat; bit bok; logic bd; logic [2*W-1:0] exp;
    launch(F_MULTU, '1, '1, 1);
    await_done(1, lat, bok, bd);
    total++; if (lat != MUL_LAT) begin bad++; $display("FAIL multu_max latency: got %0d want %0d", lat, MUL_LAT); end
    total++; if (!bok) begin bad++; $display("FAIL multu_max busy_during: got 0 want 1"); end
    total++; if (bd !== 1'b0) begin bad++; $display("FAIL multu_max busy_at_done: got %b want 0", bd); end
    total++; if (sb_q.size() != 1) begin bad++; $display("FAIL multu_max sb_depth: got %0d want 1", sb_q.size()); end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    total++; if (hi !== exp[2*W-1:W]) begin bad++; $display("FAIL multu_max hi: got %h want %h", hi, exp[2*W-1:W]); end
    total++; if (lo !== exp[W-1:0]) begin bad++; $display("FAIL multu_max lo: got %h want %h", lo, exp[W-1:0]); end
    cur_hi = exp[2*W-1:W];
    cur_lo = exp[W-1:0];
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_max done_pulse: got %b want 0", done); end
  endtask

  task automatic test_signed_ops();
    logic [3:0]   tf[8] = '{F_MULT, F_DIV, F_DIV, F_DIVU, F_DIV, F_MULT, F_DIV, F_DIVU};
    logic [W-1:0] ta[8] = '{32'hFFFFFFFE, 32'hFFFFFFF9, 32'h80000000, 32'd7,
                            32'hFFFFFFF9, 32'h80000000, 32'd100, 32'hDEADBEEF};
    logic [W-1:0] tb[8] = '{32'd3, 32'd2, 32'hFFFFFFFF, 32'd0,
                            32'd0, 32'h80000000, 32'hFFFFFFF9, 32'd1};
    int lat, want_lat; bit bok; logic bd; logic [2*W-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      launch(tf[i], ta[i], tb[i], 1);
      await_done(1, lat, bok, bd);
      want_lat = (tf[i] == F_MULT || tf[i] == F_MULTU) ? MUL_LAT : DIV_LAT;
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      total++; if (lat != want_lat) begin bad++; $display("FAIL op%0d latency: got %0d want %0d", i, lat, want_lat); end
      total++; if (!bok) begin bad++; $display("FAIL op%0d busy_during: got 0 want 1", i); end
      total++; if (hi !== exp[2*W-1:W]) begin bad++; $display("FAIL op%0d hi: got %h want %h", i, hi, exp[2*W-1:W]); end
      total++; if (lo !== exp[W-1:0]) begin bad++; $display("FAIL op%0d lo: got %h want %h", i, lo, exp[W-1:0]); end
      cur_hi = exp[2*W-1:W];
      cur_lo = exp[W-1:0];
      tick();
    end
  endtask

  task automatic test_hilo_write();
    int lat; bit bok; logic bd; logic [2*W-1:0] exp;
    hi_we = 1'b1; wdata = 32'h1234;
    tick();
    hi_we = 1'b0;
    total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mthi: got %h want 00001234", hi); end
    lo_we = 1'b1; flush = 1'b1; wdata = 32'h5678;
    tick();
    lo_we = 1'b0; flush = 1'b0;
    total++; if (lo !== 32'h5678) begin bad++; $display("FAIL mtlo_with_idle_flush: got %h want 00005678", lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_flush busy: got %b want 0", busy); end
    cur_hi = 32'h1234;
    cur_lo = 32'h5678;
    launch(F_DIVU, 32'd100, 32'd7, 1);
    repeat (4) tick();
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD0000;
    tick();
    lo_we = 1'b0; hi_we = 1'b0;
    total++; if (lo !== cur_lo) begin bad++; $display("FAIL busy_mtlo_dropped: got %h want %h", lo, cur_lo); end
    total++; if (hi !== cur_hi) begin bad++; $display("FAIL busy_mthi_dropped: got %h want %h", hi, cur_hi); end
    await_done(6, lat, bok, bd);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    total++; if (lat != DIV_LAT) begin bad++; $display("FAIL divu_100_7 latency: got %0d want %0d", lat, DIV_LAT); end
    total++; if (lo !== exp[W-1:0]) begin bad++; $display("FAIL divu_100_7 lo: got %h want %h", lo, exp[W-1:0]); end
    total++; if (hi !== exp[2*W-1:W]) begin bad++; $display("FAIL divu_100_7 hi: got %h want %h", hi, exp[2*W-1:W]); end
    tick();
    hi_we = 1'b1; wdata = 32'hABCD;
    launch(F_MULTU, 32'd5, 32'd6, 1);
    hi_we = 1'b0;
    total++; if (hi !== 32'hABCD) begin bad++; $display("FAIL mthi_with_start: got %h want 0000abcd", hi); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mthi_with_start busy: got %b want 1", busy); end
    await_done(2, lat, bok, bd);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    total++; if (hi !== exp[2*W-1:W]) begin bad++; $display("FAIL mthi_with_start result hi: got %h want %h", hi, exp[2*W-1:W]); end
    total++; if (lo !== exp[W-1:0]) begin bad++; $display("FAIL mthi_with_start result lo: got %h want %h", lo, exp[W-1:0]); end
    cur_hi = exp[2*W-1:W];
    cur_lo = exp[W-1:0];
    tick();
  endtask

  task automatic test_flush();
    logic [3:0] ff[2];
    int fc[2];
    int seen;
    ff[0] = F_MULTU; fc[0] = (MUL_LAT - 1 < 10) ? MUL_LAT - 1 : 10;
    ff[1] = F_DIVU;  fc[1] = DIV_LAT - 1;
    for (int i = 0; i < 2; i++) begin
      launch(ff[i], 32'd5, 32'd6, 0);
      for (int c = 1; c < fc[i]; c++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush%0d busy: got %b want 0", i, busy); end
      seen = 0;
      for (int c = 0; c < 40; c++) begin
        if (done === 1'b1) seen++;
        tick();
      end
      total++; if (seen != 0) begin bad++; $display("FAIL flush%0d done_pulses: got %0d want 0", i, seen); end
      total++; if (hi !== cur_hi) begin bad++; $display("FAIL flush%0d hi: got %h want %h", i, hi, cur_hi); end
      total++; if (lo !== cur_lo) begin bad++; $display("FAIL flush%0d lo: got %h want %h", i, lo, cur_lo); end
    end
    launch(F_MULTU, 32'd5, 32'd6, 0);
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midop_reset busy: got %b want 0", busy); end
    total++; if (hi !== '0) begin bad++; $display("FAIL midop_reset hi: got %h want 0", hi); end
    total++; if (lo !== '0) begin bad++; $display("FAIL midop_reset lo: got %h want 0", lo); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midop_reset done_pulses: got %0d want 0", seen); end
    cur_hi = '0;
    cur_lo = '0;
  endtask

  task automatic test_back_to_back();
    int lat, seen; bit bok; logic bd; logic [2*W-1:0] exp;
    launch(F_MULTU, 32'd2, 32'd3, 1);
    await_done(1, lat, bok, bd);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    total++; if (hi !== exp[2*W-1:W]) begin bad++; $display("FAIL b2b first hi: got %h want %h", hi, exp[2*W-1:W]); end
    total++; if (lo !== exp[W-1:0]) begin bad++; $display("FAIL b2b first lo: got %h want %h", lo, exp[W-1:0]); end
    launch(F_DIVU, 32'd9, 32'd4, 1);
    tick();
    funct = F_MULTU; a = 32'd1; b = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    await_done(3, lat, bok, bd);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    total++; if (lat != DIV_LAT) begin bad++; $display("FAIL b2b second latency: got %0d want %0d", lat, DIV_LAT); end
    total++; if (lo !== exp[W-1:0]) begin bad++; $display("FAIL b2b second lo: got %h want %h", lo, exp[W-1:0]); end
    total++; if (hi !== exp[2*W-1:W]) begin bad++; $display("FAIL b2b second hi: got %h want %h", hi, exp[2*W-1:W]); end
    tick();
    funct = 4'b0000; a = 32'd3; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL illegal_funct busy: got %b want 0", busy); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL stray_done_pulses: got %0d want 0", seen); end
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed_ops();
    test_hilo_write();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
